// File: rtl/sram_test_pkg.sv
// sram_test_pkg: shared types and widths for the SRAM read/write pattern testers
package sram_test_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic logic [DATA_W-1:0] expected_word(input logic [DATA_W-1:0] seed, input logic [ADDR_W-1:0] a);
    return seed - DATA_W'(a);
  endfunction
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: valid/address delay line matching the memory read latency
module sram_rd_pipe
  import sram_test_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);
  logic [READ_LAT-1:0] v;
  logic [ADDR_W-1:0]   a [READ_LAT];
  always_ff @(posedge CLK) begin
    for (int i = READ_LAT - 1; i > 0; i--) begin
      v[i] <= v[i-1];
      a[i] <= a[i-1];
    end
    v[0] <= in_valid;
    a[0] <= in_addr;
    if (rst) v <= '0;
  end
  assign out_valid = v[READ_LAT-1];
  assign out_addr  = a[READ_LAT-1];
endmodule

// File: rtl/sram_read_checker.sv
// sram_read_checker: sweeps addresses 0..DEPTH-1 and checks each word against SEED - addr
module sram_read_checker
  import sram_test_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 2,
  parameter int SEED     = 127
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr,
  output logic              nOutput,
  output logic              nWrite,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, p_addr;
  logic p_valid, issue, last, go, mism;
  assign issue = state == ISSUE;
  assign last  = cnt == ADDR_W'(DEPTH - 1);
  assign go    = start && (state == IDLE || state == DONE);
  sram_rd_pipe #(.READ_LAT(READ_LAT)) u_pipe (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (issue),
    .in_addr   (cnt),
    .out_valid (p_valid),
    .out_addr  (p_addr)
  );
  assign mism = p_valid && data_in != expected_word(DATA_W'(SEED), p_addr);
  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // the last compare and the move to DONE share an edge, so results are final on entry
  always_comb begin
    state_n = state;
    if (state == IDLE || state == DONE) state_n = start ? ISSUE : state;
    else if (issue) state_n = last ? DRAIN : ISSUE;
    else state_n = (p_valid && p_addr == ADDR_W'(DEPTH - 1)) ? DONE : DRAIN;
  end
  always_ff @(posedge CLK) begin
    if (rst || go) begin
      cnt             <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      if (issue && !last) cnt <= cnt + 1'b1;
      if (mism) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!first_err_valid) begin
          first_err_addr  <= p_addr;
          first_err_valid <= 1'b1;
        end
      end
    end
  end
  always_comb begin
    busy    = state == ISSUE || state == DRAIN;
    done    = state == DONE;
    pass    = done && err_count == 8'd0;
    nOutput = !busy;
    nWrite  = 1'b1;
    addr    = busy ? cnt : '0;
  end
endmodule
